// File: rtl/switch_pkg.sv
// Shared definitions for the switch combination detector.
//   state_e         : detector FSM states (armed / done / failed)
//   DefaultReqMask  : default required-switch mask (switches 1,6,7,8,9,11,13)
//   count_width()   : bits needed to hold a count of 0..n required switches
package switch_pkg;

  typedef enum logic [1:0] {
    StArmed = 2'd0,
    StDone  = 2'd1,
    StFail  = 2'd2
  } state_e;

  localparam logic [15:0] DefaultReqMask = 16'b0010_1011_1100_0010;

  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single switch input conditioner: 2-flop synchroniser, debounce filter and
// rising-edge pulse on the debounced level.
//   CLOCK  : system clock, rising edge
//   RESETN : asynchronous active-low reset
//   sw     : raw asynchronous switch level
//   rise   : one-cycle pulse when the debounced level goes 0 -> 1
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic CLOCK,
  input  logic RESETN,
  input  logic sw,
  output logic rise
);

  localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic sync1_q, sync2_q, prev_q;
  logic level;

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end

  if (DEBOUNCE_CYC == 0) begin : g_bypass
    assign level = sync2_q;
  end else begin : g_filter
    logic            db_q, db_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync2_q != db_q) begin
        if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
          db_d = sync2_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN) begin
        db_q  <= 1'b0;
        cnt_q <= '0;
      end else begin
        db_q  <= db_d;
        cnt_q <= cnt_d;
      end
    end

    assign level = db_q;
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/switch_combo_detector.sv
// Detects that every switch in REQ_MASK has been raised (optionally in
// ascending order), with forbidden-switch detection, timeout and clear.
//   CLOCK  : system clock, rising edge
//   RESETN : asynchronous active-low reset
//   full   : qualifier for index
//   clear  : synchronous clear of progress back to armed
//   sw     : raw switch levels
//   index  : combination complete and full
//   fail   : sticky failure flag
//   seen   : sticky accepted-switch bits
//   count  : number of required switches seen
module switch_combo_detector
  import switch_pkg::*;
#(
  parameter int unsigned       NUM_SW       = 16,
  parameter logic [NUM_SW-1:0] REQ_MASK     = DefaultReqMask,
  parameter bit                ORDERED      = 1'b0,
  parameter bit                STRICT       = 1'b0,
  parameter int unsigned       DEBOUNCE_CYC = 4,
  parameter int unsigned       TIMEOUT_CYC  = 0
) (
  input  logic                            CLOCK,
  input  logic                            RESETN,
  input  logic                            full,
  input  logic                            clear,
  input  logic [NUM_SW-1:0]               sw,
  output logic                            index,
  output logic                            fail,
  output logic [NUM_SW-1:0]               seen,
  output logic [count_width(NUM_SW)-1:0]  count
);

  localparam int unsigned CntW = count_width(NUM_SW);
  localparam int unsigned TmoW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [NUM_SW-1:0] ev;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
      .CLOCK (CLOCK),
      .RESETN(RESETN),
      .sw    (sw[g]),
      .rise  (ev[g])
    );
  end

  state_e            state_q, state_d;
  logic [NUM_SW-1:0] seen_q, seen_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              started_q, started_d;

  logic [NUM_SW-1:0] req_ev, opt_ev, pending, next_req;
  logic              order_err, strict_err, accept, complete, tmo_hit;

  // Event classification against current progress.
  always_comb begin
    req_ev     = ev & REQ_MASK;
    opt_ev     = ev & ~REQ_MASK;
    pending    = REQ_MASK & ~seen_q;
    next_req   = pending & (~pending + NUM_SW'(1));  // lowest outstanding required bit
    order_err  = ORDERED && (req_ev != '0) && (req_ev != next_req);
    strict_err = STRICT && (opt_ev != '0);
    accept     = (ev != '0) && !order_err && !strict_err;
  end

  // State register.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= StArmed;
      seen_q    <= '0;
      count_q   <= '0;
      tmo_q     <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seen_q    <= seen_d;
      count_q   <= count_d;
      tmo_q     <= tmo_d;
      started_q <= started_d;
    end
  end

  // Next state.
  always_comb begin
    state_d   = state_q;
    seen_d    = seen_q;
    tmo_d     = tmo_q;
    started_d = started_q;
    tmo_hit   = 1'b0;
    complete  = 1'b0;
    if (clear) begin
      state_d   = StArmed;
      seen_d    = '0;
      tmo_d     = '0;
      started_d = 1'b0;
    end else if (state_q == StArmed) begin
      if (!order_err) begin
        seen_d = seen_q | req_ev;
        if (!STRICT) seen_d = seen_d | opt_ev;
      end
      if (started_q) begin
        tmo_d   = tmo_q + TmoW'(1);
        tmo_hit = (TIMEOUT_CYC != 0) && (tmo_q == TmoW'(TIMEOUT_CYC - 1));
      end else if (accept) begin
        started_d = 1'b1;
      end
      complete = (seen_d & REQ_MASK) == REQ_MASK;
      // Completion beats a same-cycle timeout; a bad event beats both.
      if (order_err || strict_err) begin
        state_d = StFail;
      end else if (complete) begin
        state_d = StDone;
      end else if (tmo_hit) begin
        state_d = StFail;
      end
    end
    count_d = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      count_d = count_d + CntW'(seen_d[i] & REQ_MASK[i]);
    end
  end

  // Outputs.
  always_comb begin
    index = (state_q == StDone) && full;
    fail  = (state_q == StFail);
  end

  assign seen  = seen_q;
  assign count = count_q;

endmodule

// File: tb/tb_switch_combo_detector.sv
module tb_switch_combo_detector;

  localparam int NI = 5;
  localparam logic [15:0] REQ = 16'b0010_1011_1100_0010;
  // Per-instance configuration: ordered, strict, debounce, timeout.
  localparam int C_ORD[NI] = '{0, 1, 0, 0, 1};
  localparam int C_STR[NI] = '{0, 0, 1, 0, 1};
  localparam int C_DB[NI]  = '{4, 4, 4, 4, 0};
  localparam int C_TMO[NI] = '{0, 0, 0, 50, 20};
  localparam int ORDER[7]  = '{1, 6, 7, 8, 9, 11, 13};

  logic        CLOCK  = 1'b0;
  logic        RESETN = 1'b0;
  logic        full   = 1'b1;
  logic        clear  = 1'b0;
  logic [15:0] sw     = '0;

  logic        idx_a[NI];
  logic        fail_a[NI];
  logic [15:0] seen_a[NI];
  logic [4:0]  cnt_a[NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLOCK = ~CLOCK;

  switch_combo_detector #(.ORDERED(1'b0), .STRICT(1'b0), .DEBOUNCE_CYC(4), .TIMEOUT_CYC(0)) u_dut0 (
    .CLOCK(CLOCK), .RESETN(RESETN), .full(full), .clear(clear), .sw(sw),
    .index(idx_a[0]), .fail(fail_a[0]), .seen(seen_a[0]), .count(cnt_a[0]));
  switch_combo_detector #(.ORDERED(1'b1), .STRICT(1'b0), .DEBOUNCE_CYC(4), .TIMEOUT_CYC(0)) u_dut1 (
    .CLOCK(CLOCK), .RESETN(RESETN), .full(full), .clear(clear), .sw(sw),
    .index(idx_a[1]), .fail(fail_a[1]), .seen(seen_a[1]), .count(cnt_a[1]));
  switch_combo_detector #(.ORDERED(1'b0), .STRICT(1'b1), .DEBOUNCE_CYC(4), .TIMEOUT_CYC(0)) u_dut2 (
    .CLOCK(CLOCK), .RESETN(RESETN), .full(full), .clear(clear), .sw(sw),
    .index(idx_a[2]), .fail(fail_a[2]), .seen(seen_a[2]), .count(cnt_a[2]));
  switch_combo_detector #(.ORDERED(1'b0), .STRICT(1'b0), .DEBOUNCE_CYC(4), .TIMEOUT_CYC(50)) u_dut3 (
    .CLOCK(CLOCK), .RESETN(RESETN), .full(full), .clear(clear), .sw(sw),
    .index(idx_a[3]), .fail(fail_a[3]), .seen(seen_a[3]), .count(cnt_a[3]));
  switch_combo_detector #(.ORDERED(1'b1), .STRICT(1'b1), .DEBOUNCE_CYC(0), .TIMEOUT_CYC(20)) u_dut4 (
    .CLOCK(CLOCK), .RESETN(RESETN), .full(full), .clear(clear), .sw(sw),
    .index(idx_a[4]), .fail(fail_a[4]), .seen(seen_a[4]), .count(cnt_a[4]));

  // Reference model. Debounce is judged from a window of past synchronised
  // samples; progress is 0 = armed, 1 = done, 2 = failed.
  logic [15:0] m_s1, m_s2;
  logic [15:0] m_hist[8];
  logic [15:0] m_lvl[NI], m_lvlp[NI], m_seen[NI];
  int          m_state[NI], m_tmo[NI];
  bit          m_started[NI];

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] t=%0t: got %0h, expected %0h", name, inst, $time, act, exp);
    end
  endtask

  function automatic int first_missing(input logic [15:0] s);
    logic [15:0] r = REQ;
    for (int b = 0; b < 16; b++) if (r[b] && !s[b]) return b;
    return -1;
  endfunction

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    for (int j = 0; j < 8; j++) m_hist[j] = '0;
    for (int i = 0; i < NI; i++) begin
      m_lvl[i] = '0; m_lvlp[i] = '0; m_seen[i] = '0;
      m_state[i] = 0; m_tmo[i] = 0; m_started[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [15:0] ev, nl, req_ev, opt_ev, ns2;
    int want;
    bit bad_order, bad_strict, fired, all_diff;
    ns2 = m_s1;
    for (int i = 0; i < NI; i++) begin
      ev = m_lvl[i] & ~m_lvlp[i];
      if (clear) begin
        m_seen[i] = '0; m_tmo[i] = 0; m_started[i] = 1'b0; m_state[i] = 0;
      end else if (m_state[i] == 0) begin
        req_ev = ev & REQ;
        opt_ev = ev & ~REQ;
        want = first_missing(m_seen[i]);
        bad_order = (C_ORD[i] != 0) && (req_ev != 0) &&
                    !(want >= 0 && req_ev == (16'h1 << want));
        bad_strict = (C_STR[i] != 0) && (opt_ev != 0);
        if (!bad_order) begin
          m_seen[i] |= req_ev;
          if (C_STR[i] == 0) m_seen[i] |= opt_ev;
        end
        fired = 1'b0;
        if (m_started[i]) begin
          m_tmo[i]++;
          fired = (C_TMO[i] != 0) && (m_tmo[i] == C_TMO[i]);
        end else if (ev != 0 && !bad_order && !bad_strict) begin
          m_started[i] = 1'b1;
          m_tmo[i] = 0;
        end
        if (bad_order || bad_strict) m_state[i] = 2;
        else if ((m_seen[i] & REQ) == REQ) m_state[i] = 1;
        else if (fired) m_state[i] = 2;
      end
      if (C_DB[i] == 0) begin
        nl = ns2;
      end else begin
        nl = m_lvl[i];
        for (int b = 0; b < 16; b++) begin
          all_diff = 1'b1;
          for (int j = 0; j < C_DB[i]; j++) if (m_hist[j][b] == m_lvl[i][b]) all_diff = 1'b0;
          if (all_diff) nl[b] = ~m_lvl[i][b];
        end
      end
      m_lvlp[i] = m_lvl[i];
      m_lvl[i]  = nl;
    end
    for (int j = 7; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = ns2;
    m_s2 = ns2;
    m_s1 = sw;
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      chk("seen", i, 32'(seen_a[i]), 32'(m_seen[i]));
      chk("count", i, 32'(cnt_a[i]), 32'($countones(m_seen[i] & REQ)));
      chk("fail", i, 32'(fail_a[i]), 32'(m_state[i] == 2));
      chk("index", i, 32'(idx_a[i]), 32'((m_state[i] == 1) && full));
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLOCK or negedge RESETN);
      if (!RESETN) model_reset();
      else model_step();
      #1 compare_all();
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  task automatic raise_all();
    for (int k = 0; k < 7; k++) begin
      sw[ORDER[k]] = 1'b1;
      cyc(10);
    end
  endtask

  task automatic settle_and_clear();
    sw = '0;
    cyc(10);
    pulse_clear();
  endtask

  initial begin
    int b;
    cyc(3);
    chk("rst_seen", 0, 32'(seen_a[0]), 32'h0);
    chk("rst_count", 0, 32'(cnt_a[0]), 32'h0);
    chk("rst_fail", 0, 32'(fail_a[0]), 32'h0);
    chk("rst_index", 0, 32'(idx_a[0]), 32'h0);
    RESETN = 1'b1;
    cyc(2);

    // One switch at a time, ascending.
    for (int k = 0; k < 7; k++) begin
      sw[ORDER[k]] = 1'b1;
      if (k < 6) begin
        cyc(10);
        chk("count_step", 0, 32'(cnt_a[0]), 32'(k + 1));
      end else begin
        cyc(6);
        chk("index_early", 0, 32'(idx_a[0]), 32'h0);
        cyc(1);
        chk("index_on", 0, 32'(idx_a[0]), 32'h1);
        chk("fail_clean", 0, 32'(fail_a[0]), 32'h0);
        cyc(3);
      end
    end
    chk("timeout_fail", 3, 32'(fail_a[3]), 32'h1);

    // Clear with switches still high, then the full qualifier.
    pulse_clear();
    chk("clear_seen", 0, 32'(seen_a[0]), 32'h0);
    cyc(10);
    chk("no_retrigger", 0, 32'(seen_a[0]), 32'h0);
    full = 1'b0;
    sw = '0;
    cyc(10);
    raise_all();
    chk("count_full0", 0, 32'(cnt_a[0]), 32'h7);
    chk("index_full0", 0, 32'(idx_a[0]), 32'h0);
    full = 1'b1;
    #1 chk("full_rise", 0, 32'(idx_a[0]), 32'h1);
    full = 1'b0;
    #1 chk("full_fall", 0, 32'(idx_a[0]), 32'h0);
    full = 1'b1;
    cyc(1);

    // Glitch rejection on sw[6].
    settle_and_clear();
    sw[6] = 1'b1; cyc(2); sw[6] = 1'b0;
    cyc(10);
    chk("glitch2", 0, 32'(seen_a[0][6]), 32'h0);
    sw[6] = 1'b1; cyc(5); sw[6] = 1'b0;
    cyc(10);
    chk("hold5", 0, 32'(seen_a[0][6]), 32'h1);
    chk("hold5_count", 0, 32'(cnt_a[0]), 32'h1);

    // Ordered mode.
    settle_and_clear();
    sw[6] = 1'b1;
    cyc(10);
    chk("ord_wrong_fail", 1, 32'(fail_a[1]), 32'h1);
    chk("ord_wrong_seen", 1, 32'(seen_a[1]), 32'h0);
    settle_and_clear();
    sw[1] = 1'b1; sw[6] = 1'b1;
    cyc(10);
    chk("ord_pair_fail", 1, 32'(fail_a[1]), 32'h1);
    settle_and_clear();
    raise_all();
    chk("ord_index", 1, 32'(idx_a[1]), 32'h1);
    chk("ord_nofail", 1, 32'(fail_a[1]), 32'h0);

    // Strict versus lax on a non-required switch.
    settle_and_clear();
    sw[0] = 1'b1;
    cyc(10);
    chk("strict_fail", 2, 32'(fail_a[2]), 32'h1);
    chk("lax_seen0", 0, 32'(seen_a[0][0]), 32'h1);
    chk("lax_count", 0, 32'(cnt_a[0]), 32'h0);
    chk("lax_fail", 0, 32'(fail_a[0]), 32'h0);

    // Timeout, then reset mid-run.
    settle_and_clear();
    sw[1] = 1'b1;
    cyc(56);
    chk("tmo_early", 3, 32'(fail_a[3]), 32'h0);
    cyc(1);
    chk("tmo_hit", 3, 32'(fail_a[3]), 32'h1);
    cyc(3);
    #3 RESETN = 1'b0;
    #1;
    chk("rst_mid_fail", 3, 32'(fail_a[3]), 32'h0);
    chk("rst_mid_seen", 0, 32'(seen_a[0]), 32'h0);
    chk("rst_mid_count", 3, 32'(cnt_a[3]), 32'h0);
    cyc(2);
    RESETN = 1'b1;
    cyc(6);
    chk("rel_early", 0, 32'(seen_a[0][1]), 32'h0);
    cyc(1);
    chk("rel_seen1", 0, 32'(seen_a[0][1]), 32'h1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) b = ORDER[$urandom_range(0, 6)];
        else b = int'($urandom_range(0, 15));
        sw[b] = ~sw[b];
      end
      clear = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 15) == 0) full = ~full;
      RESETN = ($urandom_range(0, 699) != 0);
      cyc(1);
    end
    RESETN = 1'b1;
    clear = 1'b0;
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
